rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between NREQ requesters (ALU writeback, load unit, etc.) using round-robin arbitration.
- Captures the winning request into a one-entry output register.
- Drives the register file with a one-hot 32-bit write-enable (5-to-32 decode of the captured address), plus registered address and data.
- Back-pressure from the register file is honoured with a ready signal.

---
 rtl/rf_write_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the single register-file write port
// Optional build macro RF_ZERO_REG_DISCARD_EN: acked requests to register 0 are dropped.
module rf_write_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*5-1:0]      req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ack,
  input  logic                   rf_ready,
  output logic [31:0]            wr_en,
  output logic [4:0]             wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [31:0]         wr_en_q, wr_en_d;
  logic [4:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [PTR_W-1:0]    grant_idx;
  logic                found;
  logic [4:0]          grant_addr;
  logic [DATA_W-1:0]   grant_data;
  logic                can_accept;
  logic                accept;
  logic                load;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        grant_addr = req_addr[5*i +: 5];
        grant_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (rf_ready) state_d = load ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    can_accept = (state_q == EMPTY) || rf_ready;
    accept     = found && can_accept && !rst;
    req_ack    = accept ? (NREQ'(1) << grant_idx) : '0;
    busy       = (state_q == FULL);
`ifdef RF_ZERO_REG_DISCARD_EN
    load       = accept && (grant_addr != 5'd0);
`else
    load       = accept;
`endif
  end

  // A drained slot clears wr_en only; address and data keep their last value.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      ptr_d = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);
    end
    if (load) begin
      wr_en_d   = 32'd1 << grant_addr;
      wr_addr_d = grant_addr;
      wr_data_d = grant_data;
    end else if ((state_q == FULL) && rf_ready) begin
      wr_en_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - bench for rf_write_arbiter: pending-write model plus directed vectors
module tb_rf_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*5-1:0]      req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ack;
  logic                   rf_ready;
  logic [31:0]            wr_en;
  logic [4:0]             wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   busy;

  int n_total = 0;
  int n_pass  = 0;

  rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ack(req_ack), .rf_ready(rf_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[5*i +: 5]           = a;
    req_data[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: at most one pending write, a rotating priority pointer.
  bit        m_pending;
  int        m_addr;
  logic [31:0] m_data;
  int        m_ptr;

  always @(negedge clk) begin
    int g;
    bit fnd;
    bit can;
    logic [NREQ-1:0] e_ack;
    if (rst) begin
      m_pending = 0; m_addr = 0; m_data = 0; m_ptr = 0;
      check("m_ack_rst", req_ack, 0);
      check("m_wr_en_rst", wr_en, 0);
      check("m_busy_rst", busy, 0);
    end else begin
      fnd = 0; g = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!fnd && req_valid[(m_ptr + k) % NREQ]) begin
          fnd = 1;
          g = (m_ptr + k) % NREQ;
        end
      end
      can   = !m_pending || rf_ready;
      e_ack = (fnd && can) ? NREQ'(1 << g) : '0;
      check("m_ack", req_ack, e_ack);
      check("m_wr_en", wr_en, m_pending ? (64'd1 << m_addr) : 64'd0);
      check("m_wr_addr", wr_addr, m_addr);
      check("m_wr_data", wr_data, m_data);
      check("m_busy", busy, m_pending);
      if (fnd && can) begin
        int ga;
        bit ld;
        ga = int'(req_addr[5*g +: 5]);
        m_ptr = (g + 1) % NREQ;
`ifdef RF_ZERO_REG_DISCARD_EN
        ld = (ga != 0);
`else
        ld = 1;
`endif
        if (ld) begin
          m_pending = 1;
          m_addr    = ga;
          m_data    = req_data[DATA_W*g +: DATA_W];
        end else if (m_pending && rf_ready) begin
          m_pending = 0;
        end
      end else if (m_pending && rf_ready) begin
        m_pending = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rf_ready = 1'b1;
    tick(); tick();
    check("reset_wr_en", wr_en, 0);
    check("reset_busy", busy, 0);
    check("reset_ack", req_ack, 0);
    rst = 1'b0;

    // Round-robin with all four requesters valid.
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h1000 + i);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_ack", req_ack, 64'd1 << (k % 4));
      tick();
      check("rr_wr_en", wr_en, 64'd1 << (k % 4 + 1));
    end
    req_valid = '0;
    tick();

    // Single request from requester 2.
    set_req(2, 5'd17, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1;
    check("single_ack", req_ack, 4'b0100);
    tick();
    req_valid = '0;
    check("single_wr_en", wr_en, 32'h00020000);
    check("single_wr_addr", wr_addr, 17);
    check("single_wr_data", wr_data, 32'hDEADBEEF);
    check("single_busy", busy, 1);
    tick();
    check("single_drain", wr_en, 0);

    // Wrap-around: pointer sits at 3.
    set_req(0, 5'd5, 32'hA0);
    set_req(3, 5'd6, 32'hA3);
    req_valid = 4'b1001;
    #1;
    check("wrap_ack3", req_ack, 4'b1000);
    tick();
    check("wrap_wr_en3", wr_en, 32'h40);
    check("wrap_ack0", req_ack, 4'b0001);
    tick();
    req_valid = '0;
    check("wrap_wr_en0", wr_en, 32'h20);
    tick();

    // Back-pressure with address 31 pending.
    set_req(0, 5'd31, 32'hB0);
    set_req(1, 5'd9, 32'hB1);
    req_valid = 4'b0001;
    tick();
    rf_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ack", req_ack, 0);
      check("bp_wr_en", wr_en, 32'h80000000);
      tick();
    end
    rf_ready = 1'b1;
    #1;
    check("bp_release_ack", req_ack, 4'b0010);
    tick();
    req_valid = '0;
    check("bp_next_wr_en", wr_en, 32'h200);
    tick();

    // Zero register request.
    set_req(0, 5'd0, 32'hC0);
    req_valid = 4'b0001;
    #1;
    check("zero_ack", req_ack, 4'b0001);
    tick();
    req_valid = '0;
`ifdef RF_ZERO_REG_DISCARD_EN
    check("zero_wr_en", wr_en, 0);
    check("zero_busy", busy, 0);
`else
    check("zero_wr_en", wr_en, 32'h1);
    check("zero_busy", busy, 1);
`endif
    tick();

    // Reset while a write to register 8 is pending.
    set_req(0, 5'd8, 32'hD0);
    req_valid = 4'b0001;
    tick();
    check("rst_pre_wr_en", wr_en, 32'h100);
    rf_ready = 1'b0;
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ack", req_ack, 0);
    tick();
    rst = 1'b0;
    rf_ready = 1'b1;
    #1;
    check("rst_first_grant", req_ack, 4'b0001);
    tick();
    req_valid = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
